// File: rtl/bmp_frame_writer.sv
// rtl/bmp_frame_writer.sv - captures a processed frame into a buffer and emits it as a 24-bit BMP byte stream
module bmp_frame_writer #(
    parameter int MAX_WIDTH  = 768,
    parameter int MAX_HEIGHT = 512
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        in_valid,
    input  logic [31:0] in_width,
    input  logic [31:0] in_height,
    input  logic [10:0] in_row,
    input  logic [10:0] in_col,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_done,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_done,
    output logic        err
);

    localparam int DEPTH  = MAX_WIDTH * MAX_HEIGHT * 3;
    localparam int ADDR_W = ($clog2(DEPTH) > 21) ? $clog2(DEPTH) : 21;

    typedef enum logic [1:0] {IDLE, CAPTURE, HEADER, DATA} state_t;

    state_t            state;
    logic [31:0]       lat_w;
    logic [31:0]       lat_h;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        mem [0:DEPTH-1];

    logic [31:0]       cur_w;
    logic [31:0]       cur_h;
    logic              dims_ok;
    logic              in_range;
    logic              accept;
    logic              wr_en;
    logic              pix_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] idx_next;
    logic [31:0]       img_size;
    logic [31:0]       file_size;
    logic [54*8-1:0]   hdr;
    logic [7:0]        hdr_next;
    logic              hs;

    // The pixel that opens a frame arrives in IDLE, before the dimensions are latched.
    assign cur_w    = (state == IDLE) ? in_width  : lat_w;
    assign cur_h    = (state == IDLE) ? in_height : lat_h;
    assign dims_ok  = (cur_w <= 32'(MAX_WIDTH)) && (cur_h <= 32'(MAX_HEIGHT));
    assign in_range = (32'(in_row) < cur_h) && (32'(in_col) < cur_w);
    assign accept   = in_valid && ((state == IDLE) || (state == CAPTURE));
    assign wr_en    = accept && dims_ok && in_range;
    assign pix_err  = accept && !(dims_ok && in_range);
    // BMP stores rows bottom-up, so image row 0 lands in the last file row.
    assign wr_addr  = ADDR_W'(32'd3 * (cur_w * (cur_h - 32'd1 - 32'(in_row)) + 32'(in_col)));

    assign img_size  = lat_w * lat_h * 32'd3;
    assign file_size = img_size + 32'd54;
    assign hdr = {128'd0, img_size, 32'd0, 16'd24, 16'd1, lat_h, lat_w,
                  32'd40, 32'd54, 32'd0, file_size, 8'h4D, 8'h42};
    assign idx_next = idx + ADDR_W'(1);
    assign hdr_next = hdr[{idx_next[5:0], 3'b000} +: 8];
    assign hs       = byte_valid && byte_ready;

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[wr_addr]               <= in_r;
            mem[wr_addr + ADDR_W'(1)]  <= in_g;
            mem[wr_addr + ADDR_W'(2)]  <= in_b;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= IDLE;
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            lat_w      <= 32'd0;
            lat_h      <= 32'd0;
            idx        <= '0;
        end else begin
            frame_done <= 1'b0;
            if (pix_err) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lat_w <= in_width;
                        lat_h <= in_height;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (in_done) begin
                        if (!dims_ok) begin
                            state <= IDLE;
                        end else begin
                            state      <= HEADER;
                            byte_out   <= 8'h42;
                            byte_valid <= 1'b1;
                            idx        <= '0;
                        end
                    end
                end
                HEADER: begin
                    if (hs) begin
                        if (idx == ADDR_W'(53)) begin
                            byte_valid <= 1'b0;
                            idx        <= '0;
                            if (img_size == 32'd0) begin
                                state      <= IDLE;
                                frame_done <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            idx      <= idx_next;
                            byte_out <= hdr_next;
                        end
                    end
                end
                DATA: begin
                    // The single invalid cycle on entry covers the buffer read latency.
                    if (!byte_valid) begin
                        byte_out   <= mem[idx];
                        byte_valid <= 1'b1;
                    end else if (byte_ready) begin
                        if (32'(idx) == img_size - 32'd1) begin
                            byte_valid <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            idx      <= idx_next;
                            byte_out <= mem[idx_next];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_frame_writer.sv
// tb/tb_bmp_frame_writer.sv - randomized self-checking bench for bmp_frame_writer
module tb_bmp_frame_writer;

    logic        HCLK;
    logic        HRESET;
    logic        in_valid;
    logic [31:0] in_width;
    logic [31:0] in_height;
    logic [10:0] in_row;
    logic [10:0] in_col;
    logic [7:0]  in_r;
    logic [7:0]  in_g;
    logic [7:0]  in_b;
    logic        in_done;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        frame_done;
    logic        err;

    bmp_frame_writer dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .in_valid   (in_valid),
        .in_width   (in_width),
        .in_height  (in_height),
        .in_row     (in_row),
        .in_col     (in_col),
        .in_r       (in_r),
        .in_g       (in_g),
        .in_b       (in_b),
        .in_done    (in_done),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .frame_done (frame_done),
        .err        (err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        int         row;
        int         col;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    int         n_checks;
    int         n_errors;
    pix_t       pq[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] m_r [0:15][0:15];
    logic [7:0] m_g [0:15][0:15];
    logic [7:0] m_b [0:15][0:15];
    bit         exp_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_pix(input int row, input int col, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pix_t p;
        p.row = row; p.col = col; p.r = r; p.g = g; p.b = b;
        pq.push_back(p);
    endtask

    task automatic fill_random(input int w, input int h);
        pix_t tmp;
        int   j;
        pq.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                add_pix(r, c, 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = pq.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = pq[i]; pq[i] = pq[j]; pq[j] = tmp;
        end
    endtask

    task automatic send_frame(input int w, input int h, input bit done_with_last, input bit gaps);
        in_width  = 32'(w);
        in_height = 32'(h);
        for (int i = 0; i < pq.size(); i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                @(negedge HCLK);
                in_valid = 1'b0;
                in_done  = 1'b0;
            end
            @(negedge HCLK);
            in_valid = 1'b1;
            in_row   = 11'(pq[i].row);
            in_col   = 11'(pq[i].col);
            in_r     = pq[i].r;
            in_g     = pq[i].g;
            in_b     = pq[i].b;
            in_done  = done_with_last && (i == pq.size() - 1);
            if (w <= 768 && h <= 512 && pq[i].row < h && pq[i].col < w) begin
                m_r[pq[i].row][pq[i].col] = pq[i].r;
                m_g[pq[i].row][pq[i].col] = pq[i].g;
                m_b[pq[i].row][pq[i].col] = pq[i].b;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (!done_with_last) begin
            @(negedge HCLK);
            in_valid = 1'b0;
            in_done  = 1'b1;
        end
    endtask

    task automatic push_le(input int v, input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back(8'(v >> (8 * k)));
    endtask

    task automatic build_expected(input int w, input int h);
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push_le(54 + w * h * 3, 4);
        push_le(0, 4);
        push_le(54, 4);
        push_le(40, 4);
        push_le(w, 4);
        push_le(h, 4);
        push_le(1, 2);
        push_le(24, 2);
        push_le(0, 4);
        push_le(w * h * 3, 4);
        for (int k = 0; k < 4; k++) push_le(0, 4);
        for (int fr = 0; fr < h; fr++)
            for (int c = 0; c < w; c++) begin
                exp_q.push_back(m_r[h - 1 - fr][c]);
                exp_q.push_back(m_g[h - 1 - fr][c]);
                exp_q.push_back(m_b[h - 1 - fr][c]);
            end
    endtask

    // mode 0: ready always high, 1: high one cycle in three, 2: random
    task automatic collect(input int mode, input int stop_after);
        int         cyc;
        int         first;
        int         bubbles;
        bit         stall;
        bit         rdy;
        logic [7:0] held;
        got_q.delete();
        cyc = 0; first = -1; bubbles = 0; stall = 0; held = 8'd0;
        while (got_q.size() < exp_q.size() && cyc < 3000) begin
            @(negedge HCLK);
            in_valid = 1'b0;
            in_done  = 1'b0;
            if (stall) begin
                check("stall_valid", 64'(byte_valid), 64'd1);
                check("stall_data", 64'(byte_out), 64'(held));
                stall = 0;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
            byte_ready = rdy;
            if (byte_valid) begin
                if (first < 0) first = cyc;
                if (rdy) got_q.push_back(byte_out);
                else begin
                    stall = 1;
                    held  = byte_out;
                end
            end else if (first >= 0) begin
                bubbles++;
            end
            cyc++;
            if (stop_after > 0 && got_q.size() == stop_after) return;
        end
        check("stream_len", 64'(got_q.size()), 64'(exp_q.size()));
        check("first_byte_latency", 64'(first), 64'd0);
        check("bubbles", 64'(bubbles), (exp_q.size() > 54) ? 64'd1 : 64'd0);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), (i < got_q.size()) ? 64'(got_q[i]) : 64'hx, 64'(exp_q[i]));
        @(negedge HCLK);
        byte_ready = 1'b0;
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        check("valid_after_frame", 64'(byte_valid), 64'd0);
        @(negedge HCLK);
        check("frame_done_clear", 64'(frame_done), 64'd0);
        check("err_flag", 64'(err), 64'(exp_err));
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        check("rst_valid", 64'(byte_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic directed_2x2();
        pq.delete();
        add_pix(0, 0, 8'h11, 8'h22, 8'h33);
        add_pix(0, 1, 8'h44, 8'h55, 8'h66);
        add_pix(1, 0, 8'h77, 8'h88, 8'h99);
        add_pix(1, 1, 8'hAA, 8'hBB, 8'hCC);
    endtask

    int w;
    int h;
    int cnt;

    initial begin
        n_checks = 0; n_errors = 0; exp_err = 1'b0;
        HRESET = 1'b1; in_valid = 1'b0; in_width = 32'd0; in_height = 32'd0;
        in_row = 11'd0; in_col = 11'd0; in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
        in_done = 1'b0; byte_ready = 1'b0;
        repeat (3) @(negedge HCLK);
        check("reset_byte_out", 64'(byte_out), 64'd0);
        check("reset_byte_valid", 64'(byte_valid), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        HRESET = 1'b0;

        directed_2x2();
        send_frame(2, 2, 1, 0);
        build_expected(2, 2);
        collect(0, 0);
        check("size_lsb", (got_q.size() > 5) ? 64'(got_q[2]) : 64'hx, 64'h42);
        check("first_data", (got_q.size() > 54) ? 64'(got_q[54]) : 64'hx, 64'h77);
        check("last_data", (got_q.size() > 65) ? 64'(got_q[65]) : 64'hx, 64'h66);

        directed_2x2();
        send_frame(2, 2, 1, 0);
        build_expected(2, 2);
        collect(1, 0);

        directed_2x2();
        pq.insert(2, '{row: 2, col: 1, r: 8'hDE, g: 8'hAD, b: 8'hBE});
        send_frame(2, 2, 1, 0);
        build_expected(2, 2);
        collect(2, 0);
        check("err_sticky", 64'(err), 64'd1);

        do_reset();
        pq.delete();
        add_pix(0, 0, 8'h01, 8'h02, 8'h03);
        add_pix(0, 1, 8'h04, 8'h05, 8'h06);
        send_frame(800, 2, 0, 0);
        exp_err = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge HCLK);
            in_valid = 1'b0;
            in_done  = 1'b0;
            byte_ready = 1'b1;
            if (byte_valid) cnt++;
        end
        check("bad_dims_no_output", 64'(cnt), 64'd0);
        check("bad_dims_err", 64'(err), 64'd1);
        fill_random(3, 2);
        send_frame(3, 2, 1, 1);
        build_expected(3, 2);
        collect(0, 0);

        do_reset();
        for (int t = 0; t < 6; t++) begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 6);
            fill_random(w, h);
            if ($urandom_range(0, 1) == 1)
                pq.push_back('{row: $urandom_range(0, h - 1), col: $urandom_range(0, w - 1),
                               r: 8'($urandom), g: 8'($urandom), b: 8'($urandom)});
            if (t >= 3)
                pq.insert($urandom_range(1, pq.size()),
                          '{row: $urandom_range(0, h + 3), col: w + $urandom_range(0, 3),
                            r: 8'($urandom), g: 8'($urandom), b: 8'($urandom)});
            send_frame(w, h, (pq.size() > 1) && ($urandom_range(0, 1) == 1), 1);
            build_expected(w, h);
            collect(t % 3, 0);
        end

        pq.delete();
        add_pix(0, 0, 8'h12, 8'h34, 8'h56);
        send_frame(0, 3, 0, 0);
        build_expected(0, 3);
        collect(0, 0);
        pq.delete();
        add_pix(0, 0, 8'h12, 8'h34, 8'h56);
        send_frame(3, 0, 0, 0);
        build_expected(3, 0);
        collect(2, 0);

        do_reset();
        fill_random(4, 3);
        send_frame(4, 3, 1, 0);
        build_expected(4, 3);
        collect(0, 54 + 30);
        @(posedge HCLK);
        #2;
        HRESET = 1'b1;
        #1;
        check("midframe_rst_valid", 64'(byte_valid), 64'd0);
        check("midframe_rst_byte", 64'(byte_out), 64'd0);
        check("midframe_rst_err", 64'(err), 64'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        byte_ready = 1'b0;
        exp_err = 1'b0;
        pq.delete();
        add_pix(0, 0, 8'hC1, 8'hC2, 8'hC3);
        send_frame(1, 1, 0, 0);
        build_expected(1, 1);
        collect(0, 0);
        check("one_pixel_len", 64'(got_q.size()), 64'd57);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bmp_frame_writer.md
BMP_FRAME_WRITER -- requirements
Module: bmp_frame_writer

Interface
REQ-001 Parameter MAX_WIDTH, default 768: largest accepted image width in pixels.
REQ-002 Parameter MAX_HEIGHT, default 512: largest accepted image height in pixels.
REQ-003 HCLK  input  1  single clock; all logic on rising edge.
REQ-004 HRESET  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  pixel present on in_row/in_col/in_r/in_g/in_b this cycle.
REQ-006 in_width, in_height  input  32 each  frame dimensions from processing stage.
REQ-007 in_row, in_col  input  11 each  destination pixel coordinate.
REQ-008 in_r, in_g, in_b  input  8 each  pixel components.
REQ-009 in_done  input  1  processing stage finished frame.
REQ-010 byte_out  output  8  BMP file byte stream.
REQ-011 byte_valid  output  1  byte_out holds a valid byte.
REQ-012 byte_ready  input  1  sink accepts byte_out this cycle.
REQ-013 frame_done  output  1  one-cycle pulse after last file byte accepted.
REQ-014 err  output  1  sticky error flag; cleared only by HRESET.

Function
REQ-015 FSM states IDLE, CAPTURE, HEADER, DATA; frame buffer of MAX_WIDTH*MAX_HEIGHT*3 bytes.
REQ-016 IDLE: in_valid=1 latches in_width/in_height, writes that pixel, moves to CAPTURE.
REQ-017 CAPTURE: each in_valid writes R,G,B to buffer byte offsets 3*(W*(H-1-row)+col)+0/1/2 using latched W,H.
REQ-018 Pixel with row>=H or col>=W is discarded and sets err.
REQ-019 Latched W>MAX_WIDTH or H>MAX_HEIGHT sets err; all pixels discarded; in_done returns to IDLE with no byte output.
REQ-020 in_done=1 in CAPTURE (pixel in same cycle still written) moves to HEADER; byte_valid=1 with byte_out=0x42 from next cycle.
REQ-021 in_done outside CAPTURE ignored; in_valid in HEADER/DATA ignored.
REQ-022 Header is 54 bytes, multi-byte fields little-endian: 0x42,0x4D; file size 54+W*H*3 (4); 0 (4); 54 (4); 40 (4); W (4); H (4); 1 (2); 24 (2); 0 (4); W*H*3 (4); 0 (16).
REQ-023 DATA streams buffer offsets 0..W*H*3-1 in increasing order; no row padding inserted.
REQ-024 Handshake: byte advances only when byte_valid&byte_ready; byte_out and byte_valid stable while byte_valid&!byte_ready.
REQ-025 With byte_ready held 1: one byte per cycle, exactly one byte_valid=0 cycle between last header byte and first data byte, none elsewhere.
REQ-026 W=0 or H=0 (within limits): header only, then done.
REQ-027 After last byte handshake: frame_done=1 next cycle for one cycle, state IDLE, byte_valid=0.
REQ-028 Buffer address arithmetic at least 21 bits; size fields computed in 32 bits.
REQ-029 Latched W,H held constant from CAPTURE entry until return to IDLE.

Reset
REQ-030 HRESET=1 forces state IDLE, byte_out=0, byte_valid=0, frame_done=0, err=0, latched W/H=0, immediately and regardless of state.
REQ-031 Reset mid-frame abandons the frame; buffer contents not cleared; next frame starts normally after HRESET falls.

Verification
REQ-032 W=2,H=2; pixels (0,0)=11/22/33, (0,1)=44/55/66, (1,0)=77/88/99, (1,1)=AA/BB/CC; in_done; ready=1 -> 54 header bytes (size bytes 0x42,0,0,0 at offsets 2-5), one bubble, data 77 88 99 AA BB CC 11 22 33 44 55 66, frame_done pulse.
REQ-033 Same frame, byte_ready toggled 1-of-3 cycles -> identical 66-byte sequence, byte_out stable during stalls.
REQ-034 W=2,H=2, pixel at row=2 -> err=1, pixel absent, other bytes unchanged, err persists after frame.
REQ-035 W=800 -> err=1; in_done -> IDLE, byte_valid never asserted.
REQ-036 HRESET pulsed during DATA at byte 30 -> byte_valid=0 immediately, IDLE; fresh 1x1 frame then produces 57 correct bytes.
REQ-037 in_valid and in_done same cycle as final pixel -> pixel present in output stream.
